// File: rtl/bcd_counter_4dig.sv
// ---------------------------------------------------------------------------
// bcd_counter_4dig
//   Multi-digit BCD up/down counter with a built-in tick prescaler. Each
//   nibble of `count` feeds one seven-segment decoder, so the displays show
//   a decimal value. One count step is applied every PRESCALE enabled cycles.
//
// Parameters
//   DIGITS     : number of BCD digits (count is 4*DIGITS bits)
//   PRESCALE   : clock cycles per count step (>= 2)
//   PRESCALE_W : prescaler width, 2**PRESCALE_W >= PRESCALE
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : count enable; low freezes prescaler and count
//   up         : direction (1 = increment, 0 = decrement), used on step cycle
//   clear      : synchronous clear of count and prescaler (highest priority)
//   load       : synchronous load of load_value (nibbles > 9 clamp to 9)
//   load_value : BCD value to load, digit 0 in bits [3:0]
//   count      : registered BCD count, digit k in bits [4k+3:4k]
//   tick       : one-cycle pulse on every cycle a step is applied
//   wrap       : one-cycle pulse with tick when the count wraps
// ---------------------------------------------------------------------------
module bcd_counter_4dig #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                wrap
);

  localparam int W = 4 * DIGITS;
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic                  step;
  logic [W-1:0]          step_count;
  logic                  step_wrap;
  logic [W-1:0]          load_clamped;
  logic                  carry;
  logic [3:0]            digit;

  // A step happens on the edge that ends the last prescaler cycle.
  assign step = en && (prescaler == PRESCALE_LAST);

  // Ripple increment/decrement across all digits in one cycle. `carry`
  // doubles as the borrow when counting down; if it survives past the top
  // digit, every digit rolled over and the count wrapped.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    step_count = count;
    carry      = 1'b1;
    digit      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = count[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            step_count[4*k +: 4] = 4'd0;
          end else begin
            step_count[4*k +: 4] = digit + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_count[4*k +: 4] = 4'd9;
          end else begin
            step_count[4*k +: 4] = digit - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  // Clamp each loaded nibble into 0..9 so count can never hold a non-BCD
  // digit, whatever the switches say.
  always_comb begin
    load_clamped = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_clamped[4*k +: 4] = (load_value[4*k +: 4] > 4'd9) ? 4'd9
                                                             : load_value[4*k +: 4];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      count     <= load_clamped;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (step) begin
      count     <= step_count;
      prescaler <= '0;
      tick      <= 1'b1;
      wrap      <= step_wrap;
    end else begin
      // Pulses last one cycle; the prescaler advances only while enabled.
      tick <= 1'b0;
      wrap <= 1'b0;
      if (en) prescaler <= prescaler + PRESCALE_W'(1);
    end
  end

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_4dig
//   Self-checking bench for bcd_counter_4dig (DIGITS=4, PRESCALE=4). The
//   reference model keeps the count as a plain integer 0..9999 and converts
//   it to BCD for comparison; steps are modular arithmetic on that integer.
// ---------------------------------------------------------------------------
module tb_bcd_counter_4dig;

  localparam int DIGITS     = 4;
  localparam int PRESCALE   = 4;
  localparam int PRESCALE_W = 3;
  localparam int W          = 4 * DIGITS;
  localparam int MODULUS    = 10000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         tick;
  logic         wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int   m_val  = 0;
  int   m_pre  = 0;
  logic m_tick = 1'b0;
  logic m_wrap = 1'b0;
  int   wrap_seen = 0;

  bcd_counter_4dig #(
    .DIGITS    (DIGITS),
    .PRESCALE  (PRESCALE),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamped_value(input logic [W-1:0] lv);
    int v;
    int p;
    int nib;
    v = 0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      nib = int'(lv[4*k +: 4]);
      v   = v + ((nib > 9) ? 9 : nib) * p;
      p   = p * 10;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the current inputs, then let the
  // DUT take the same edge and compare all outputs 1 time unit later.
  task automatic cyc(input string tag);
    if (clear) begin
      m_val = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
    end else if (load) begin
      m_val = clamped_value(load_value); m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
    end else if (!en) begin
      m_tick = 1'b0; m_wrap = 1'b0;
    end else if (m_pre == PRESCALE - 1) begin
      m_pre  = 0;
      m_tick = 1'b1;
      if (up) begin
        m_wrap = (m_val == MODULUS - 1);
        m_val  = (m_val + 1) % MODULUS;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MODULUS - 1) % MODULUS;
      end
    end else begin
      m_pre  = m_pre + 1;
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_seen++;
    check({tag, ".count"}, count, to_bcd(m_val));
    check({tag, ".tick"}, W'(tick), W'(m_tick));
    check({tag, ".wrap"}, W'(wrap), W'(m_wrap));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_value = v;
    load = 1'b1;
    cyc("load");
    load = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #12;
    check("por.count", count, '0);
    check("por.tick", W'(tick), '0);
    rst = 1'b0;

    // Async reset while counting from 0x0123
    en = 1'b1; up = 1'b1;
    do_load(16'h0123);
    run("pre_rst", 2);
    #2;
    rst = 1'b1;
    #1;
    m_val = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
    check("rst_async.count", count, '0);
    check("rst_async.tick", W'(tick), '0);
    @(posedge clk);
    #1;
    check("rst_held.count", count, '0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc("post_rst");
      check("post_rst.tick_pos", W'(tick), W'(i == 4));
    end

    // Up count: 10 ticks -> 0010, 100 ticks -> 0100, no wrap
    clear = 1'b1; cyc("clear"); clear = 1'b0;
    wrap_seen = 0;
    run("up10", 10 * PRESCALE);
    check("up10.value", count, 16'h0010);
    run("up100", 90 * PRESCALE);
    check("up100.value", count, 16'h0100);
    check("up100.no_wrap", W'(wrap_seen), '0);

    // Wrap up 9999 -> 0000
    do_load(16'h9999);
    run("wrap_up_wait", PRESCALE - 1);
    cyc("wrap_up");
    check("wrap_up.value", count, 16'h0000);
    check("wrap_up.tick", W'(tick), W'(1));
    check("wrap_up.wrap", W'(wrap), W'(1));
    cyc("wrap_up_after");
    check("wrap_up.pulse_end", W'(wrap), '0);

    // Wrap down 0000 -> 9999
    up = 1'b0;
    do_load(16'h0000);
    run("wrap_dn", PRESCALE);
    check("wrap_dn.value", count, 16'h9999);
    check("wrap_dn.wrap", W'(wrap), W'(1));

    // Down ripple 1000 -> 0999
    do_load(16'h1000);
    run("ripple_dn", PRESCALE);
    check("ripple_dn.value", count, 16'h0999);
    check("ripple_dn.wrap", W'(wrap), '0);

    // Priority and clamping
    clear = 1'b1; load = 1'b1; load_value = 16'h5678;
    cyc("clr_over_load");
    clear = 1'b0; load = 1'b0;
    check("clr_over_load.value", count, 16'h0000);
    do_load(16'hA3F1);
    check("clamp.value", count, 16'h9391);

    // Enable freeze
    up = 1'b1;
    do_load(16'h0000);
    run("freeze_en", 2);
    en = 1'b0;
    run("freeze_off", 10);
    check("freeze.value", count, 16'h0000);
    en = 1'b1;
    cyc("freeze_resume1");
    check("freeze.tick1", W'(tick), '0);
    cyc("freeze_resume2");
    check("freeze.tick2", W'(tick), W'(1));
    check("freeze.value2", count, 16'h0001);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      up    = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0:       load_value = 16'h9999;
        1:       load_value = 16'h0000;
        default: load_value = W'($urandom);
      endcase
      cyc("random");
    end
    clear = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_4dig.md
Name: bcd_counter_4dig

Overview:
- Multi-digit BCD up/down counter with a built-in tick prescaler.
- Each 4-bit digit of `count` drives the `data_in` of one seven-segment hex decoder instance, so the board shows a decimal count on 4 displays.
- Sits directly upstream of the hex decoders; used for stopwatch/counter lab exercises on the 50 MHz board clock.

Parameters:
- DIGITS, 4, number of BCD digits; `count` is 4*DIGITS bits wide.
- PRESCALE, 50000000, clock cycles per count step (1 Hz at 50 MHz); legal range >= 2.
- PRESCALE_W, 26, prescaler register width; must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes both prescaler and count.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only on the step cycle.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_value.
- load_value  in  4*DIGITS  BCD value to load; digit 0 = bits [3:0] (least significant).
- count  out  4*DIGITS  registered BCD count; digit k = bits [4k+3:4k].
- tick  out  1  one-cycle pulse on every cycle in which a count step is applied.
- wrap  out  1  one-cycle pulse coincident with tick when the count wraps (all-9s -> 0 up, 0 -> all-9s down).

Behaviour:
- Reset (async, rst=1): count=0, prescaler=0, tick=0, wrap=0. Held while rst is high; normal operation resumes on the first clk edge after deassertion.
- Per-edge priority: clear > load > step > hold.
- clear=1: count=0, prescaler=0, tick=0, wrap=0. Takes effect regardless of en.
- load=1 (clear=0): count=load_value with per-digit clamping (any nibble > 9 loads as 9); prescaler=0, tick=0, wrap=0. Takes effect regardless of en.
- en=0 (no clear/load): prescaler and count hold; tick=0, wrap=0.
- en=1: prescaler increments each cycle.
  - When prescaler == PRESCALE-1, the next edge sets prescaler=0 and applies one step: tick=1 for exactly that cycle.
  - Steady-state period between ticks is exactly PRESCALE cycles.
- Step up:
  - Digit 0 += 1. A digit at 9 becomes 0 and carries into the next digit (ripple, single cycle).
  - All digits 9 -> all 0 with wrap=1.
- Step down:
  - Digit 0 -= 1. A digit at 0 becomes 9 and borrows from the next digit.
  - All 0 -> all 9s with wrap=1.
- Latency:
  - count, tick and wrap are all registered and update on the same edge.
  - count reflects a load or clear one cycle after it is asserted.
- Changing `up` between ticks has no effect until the next step cycle.
- Invariant: count never holds a non-BCD nibble in any state.
- Outputs are registered, so downstream decoders see no combinational glitches.

Test Plan (PRESCALE=4, DIGITS=4):
- Reset: assert rst mid-count at 0x0123 with en=1 -> count=0x0000, tick=0 immediately without a clk edge; the first tick comes 4 cycles after rst deasserts.
- Up count: en=1, up=1 from 0 -> tick every 4th cycle. After 10 ticks count=0x0010; after 100 ticks count=0x0100; no wrap pulse.
- Wrap: load 0x9999, up=1, en=1 -> on the 4th cycle count=0x0000 with tick=1 and wrap=1 for one cycle. Then load 0x0000, up=0 -> count=0x9999, wrap=1.
- Down ripple: load 0x1000, up=0 -> after one tick count=0x0999, wrap=0.
- Priority/clamp: clear=1 and load=1 together with load_value=0x5678 -> count=0x0000. Then load_value=0xA3F1 with load=1 -> count=0x9391.
- Enable freeze: en=1 for 2 cycles, en=0 for 10 cycles, en=1 -> the next tick comes exactly 2 enabled cycles later; count unchanged while en=0.
